// File: rtl/barret_rr_sched_3221.sv
// rtl/barret_rr_sched_3221.sv - round-robin shared mod-3221 Barrett reducer, 2-stage pipe (optional BARRET_STATS_EN counters)

module barret_for_3221 (
   input  logic [22:0] x,
   output logic [11:0] r
);
   // floor(2^35 / 3221): quotient estimate is at most one short for 23-bit inputs
   localparam logic [23:0] MU = 24'd10667413;
   localparam logic [11:0] M  = 12'd3221;

   logic [46:0] prod;
   logic [11:0] q;
   logic [23:0] qm;
   logic [23:0] rem;

   // Barrett quotient estimate, then a single conditional subtract to land in [0, 3221)
   always_comb begin
      prod = {24'd0, x} * {23'd0, MU};
      q    = 12'(prod >> 35);
      qm   = {12'd0, q} * {12'd0, M};
      rem  = {1'b0, x} - qm;
      if (rem >= {12'd0, M}) begin
         rem = rem - {12'd0, M};
      end
      r = rem[11:0];
   end
endmodule

module barret_rr_sched_3221 #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 23,
   parameter int RES_W   = 12,
   parameter int TAG_W   = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [RES_W-1:0]          out_data,
   output logic [TAG_W-1:0]          out_tag,
   output logic                      busy
`ifdef BARRET_STATS_EN
   ,
   output logic [15:0]               done_cnt,
   output logic [15:0]               stall_cnt
`endif
);
   localparam logic [TAG_W:0]   NREQ     = (TAG_W+1)'(NUM_REQ);
   localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_REQ - 1);

   logic              s0_v;
   logic              s1_v;
   logic [DATA_W-1:0] s0_data;
   logic [TAG_W-1:0]  s0_tag;
   logic [RES_W-1:0]  s1_data;
   logic [TAG_W-1:0]  s1_tag;
   logic [TAG_W-1:0]  ptr;

   logic              s1_adv;
   logic              s0_adv;
   logic              grant_any;
   logic [TAG_W-1:0]  grant_idx;
   logic [TAG_W:0]    cand;
   logic [DATA_W-1:0] grant_data;
   logic [TAG_W-1:0]  ptr_next;
   logic [RES_W-1:0]  red_out;

   // Handshake advance: a stage moves when it is empty or the stage after it moves
   always_comb begin
      s1_adv = !s1_v || out_ready;
      s0_adv = !s0_v || s1_adv;
   end

   // Round-robin search from ptr upward with wrap; only grants when S0 can take data
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (rst_n && s0_adv) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (TAG_W+1)'(k);
            if (cand >= NREQ) begin
               cand = cand - NREQ;
            end
            if (!grant_any && req_valid[cand[TAG_W-1:0]]) begin
               grant_any = 1'b1;
               grant_idx = cand[TAG_W-1:0];
            end
         end
      end
      req_ready = '0;
      if (grant_any) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Operand mux and next pointer (one past the winner)
   always_comb begin
      grant_data = req_data[grant_idx*DATA_W +: DATA_W];
      ptr_next   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
   end

   barret_for_3221 u_red (
      .x (s0_data),
      .r (red_out)
   );

   // Pipeline registers and arbitration pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_v    <= 1'b0;
         s1_v    <= 1'b0;
         s0_data <= '0;
         s0_tag  <= '0;
         s1_data <= '0;
         s1_tag  <= '0;
         ptr     <= '0;
      end else begin
         if (s1_adv) begin
            s1_v <= s0_v;
            if (s0_v) begin
               s1_data <= red_out;
               s1_tag  <= s0_tag;
            end
         end
         if (s0_adv) begin
            s0_v <= grant_any;
            if (grant_any) begin
               s0_data <= grant_data;
               s0_tag  <= grant_idx;
               ptr     <= ptr_next;
            end
         end
      end
   end

   // Outputs come straight from S1
   always_comb begin
      out_valid = s1_v;
      out_data  = s1_data;
      out_tag   = s1_tag;
      busy      = s0_v || s1_v;
   end

`ifdef BARRET_STATS_EN
   // Saturating completion and stall counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (s1_v && out_ready && done_cnt != 16'hFFFF) begin
            done_cnt <= done_cnt + 16'd1;
         end
         if (s1_v && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_barret_rr_sched_3221.sv
// tb/tb_barret_rr_sched_3221.sv - scoreboard bench for barret_rr_sched_3221

module tb_barret_rr_sched_3221;
   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 23;
   localparam int RES_W   = 12;
   localparam int TAG_W   = 2;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      out_valid;
   logic                      out_ready;
   logic [RES_W-1:0]          out_data;
   logic [TAG_W-1:0]          out_tag;
   logic                      busy;
`ifdef BARRET_STATS_EN
   logic [15:0]               done_cnt;
   logic [15:0]               stall_cnt;
`endif

   barret_rr_sched_3221 #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .RES_W   (RES_W),
      .TAG_W   (TAG_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .busy      (busy)
`ifdef BARRET_STATS_EN
      ,
      .done_cnt  (done_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // stimulus per requester, scoreboard, output log
   int unsigned pend [NUM_REQ][$];
   int unsigned sb_data[$];
   int unsigned sb_tag[$];
   int unsigned logd[$];
   int unsigned logt[$];
   int unsigned logc[$];
   int unsigned vals[$];

   logic [NUM_REQ-1:0] exp_grant = '0;
   bit                 m_s0 = 1'b0;
   bit                 m_s1 = 1'b0;
   int                 m_ptr = 0;
   bit                 prev_stall = 1'b0;
   logic [RES_W-1:0]   prev_data = '0;
   logic [TAG_W-1:0]   prev_tag = '0;
   int                 dut_acc = 0;
   int                 cyc = 0;

   // Reference model: pipeline occupancy, rr pointer, expected grants and results
   always @(negedge clk) begin : monitor
      logic [NUM_REQ-1:0] eg;
      int gi;
      int c;
      bit adv1;
      bit adv0;
      int unsigned ed;
      int unsigned et;
      cyc++;
      if (!rst_n) begin
         check_val("ready_in_reset", req_ready, 0);
         m_s0 = 1'b0;
         m_s1 = 1'b0;
         m_ptr = 0;
         sb_data.delete();
         sb_tag.delete();
         exp_grant = '0;
         prev_stall = 1'b0;
      end else begin
         check_val("out_valid", out_valid, m_s1);
         check_val("busy", busy, m_s0 | m_s1);
         if (prev_stall) begin
            check_val("hold_data", out_data, prev_data);
            check_val("hold_tag", out_tag, prev_tag);
         end
         adv1 = !m_s1 || out_ready;
         adv0 = !m_s0 || adv1;
         eg = '0;
         gi = -1;
         if (adv0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               c = (m_ptr + k) % NUM_REQ;
               if (gi < 0 && req_valid[c]) gi = c;
            end
         end
         if (gi >= 0) eg[gi] = 1'b1;
         check_val("req_ready", req_ready, eg);
         if (|(req_valid & req_ready)) dut_acc++;
         if (out_valid && out_ready) begin
            if (sb_data.size() == 0) begin
               check_val("out_without_input", out_valid, 0);
            end else begin
               ed = sb_data.pop_front();
               et = sb_tag.pop_front();
               check_val("out_data", out_data, ed);
               check_val("out_tag", out_tag, et);
            end
            logd.push_back(out_data);
            logt.push_back(out_tag);
            logc.push_back(cyc);
         end
         if (gi >= 0) begin
            sb_data.push_back(int'(req_data[gi*DATA_W +: DATA_W]) % 3221);
            sb_tag.push_back(gi);
            m_ptr = (gi + 1) % NUM_REQ;
         end
         if (adv1) m_s1 = m_s0;
         if (adv0) m_s0 = (gi >= 0);
         prev_stall = out_valid && !out_ready;
         prev_data = out_data;
         prev_tag = out_tag;
         exp_grant = eg;
      end
   end

   // Requesters: present head of their queue, advance after a grant
   initial begin : driver
      req_valid = '0;
      req_data = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_grant[i] && pend[i].size() > 0) void'(pend[i].pop_front());
            if (pend[i].size() > 0) begin
               req_valid[i] = 1'b1;
               req_data[i*DATA_W +: DATA_W] = DATA_W'(pend[i][0]);
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int pending_total();
      int s = 0;
      for (int i = 0; i < NUM_REQ; i++) s += pend[i].size();
      return s;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((pending_total() != 0 || sb_data.size() != 0 || busy) && n < 500) begin
         tick(1);
         n++;
      end
      check_val("drain_busy", busy, 0);
      check_val("drain_sb_empty", sb_data.size(), 0);
   endtask

   task automatic clear_logs();
      logd.delete();
      logt.delete();
      logc.delete();
   endtask

   task automatic do_reset();
      tick(1);
      rst_n = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
      out_ready = 1'b1;
      tick(2);
      rst_n = 1'b1;
   endtask

   initial begin : stim
      int n;
      out_ready = 1'b1;
      tick(3);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_data", out_data, 0);
      check_val("rst_out_tag", out_tag, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_req_ready", req_ready, 0);
      rst_n = 1'b1;
      tick(1);

      // single request latency and reduction boundaries
      pend[0].push_back(3221);
      tick(3);
      check_val("lat_out_valid", out_valid, 1);
      check_val("lat_data_3221", out_data, 0);
      check_val("lat_tag", out_tag, 0);
      wait_drain();
      pend[0].push_back(8388607);
      tick(3);
      check_val("lat2_out_valid", out_valid, 1);
      check_val("max_operand", out_data, 1123);
      wait_drain();

      // contention from pointer 0
      do_reset();
      clear_logs();
      for (int i = 0; i < NUM_REQ; i++) pend[i].push_back(3222 + i);
      wait_drain();
      check_val("cont_count", logd.size(), 4);
      for (int i = 0; i < 4 && i < logd.size(); i++) begin
         check_val("cont_data", logd[i], i + 1);
         check_val("cont_tag", logt[i], i);
         if (i > 0) check_val("cont_consec", logc[i] - logc[i-1], 1);
      end

      // fairness between requesters 1 and 3
      clear_logs();
      for (int i = 0; i < 4; i++) begin
         pend[1].push_back(100 + i);
         pend[3].push_back(5000 + i);
      end
      wait_drain();
      check_val("fair_count", logt.size(), 8);
      for (int i = 0; i < 8 && i < logt.size(); i++) begin
         check_val("fair_tag", logt[i], (i % 2 == 0) ? 1 : 3);
      end

      // backpressure: 10 operands from requester 2, 5 stalled cycles
      clear_logs();
      vals.delete();
      vals.push_back(0);
      vals.push_back(3220);
      vals.push_back(8388607);
      for (int i = 3; i < 10; i++) vals.push_back($urandom_range(0, 8388607));
      out_ready = 1'b0;
      n = dut_acc;
      foreach (vals[i]) pend[2].push_back(vals[i]);
      tick(5);
      check_val("bp_accepted", dut_acc - n, 2);
      check_val("bp_ready_low", req_ready, 0);
      out_ready = 1'b1;
      wait_drain();
      check_val("bp_count", logd.size(), 10);
      for (int i = 0; i < 10 && i < logd.size(); i++) begin
         check_val("bp_data", logd[i], vals[i] % 3221);
         check_val("bp_tag", logt[i], 2);
      end

      // reset with both stages full
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) pend[1].push_back(7000 + i);
      tick(4);
      check_val("full_busy", busy, 1);
      check_val("full_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check_val("async_out_valid", out_valid, 0);
      check_val("async_busy", busy, 0);
      check_val("async_ready", req_ready, 0);
      for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
      out_ready = 1'b1;
      tick(2);
      rst_n = 1'b1;
      clear_logs();
      pend[3].push_back(6442);
      wait_drain();
      check_val("post_rst_count", logd.size(), 1);
      if (logd.size() > 0) begin
         check_val("post_rst_data", logd[0], 0);
         check_val("post_rst_tag", logt[0], 3);
      end

`ifdef BARRET_STATS_EN
      do_reset();
      check_val("stats_rst_done", done_cnt, 0);
      check_val("stats_rst_stall", stall_cnt, 0);
      for (int i = 0; i < 7; i++) pend[0].push_back(1000 + i);
      n = 0;
      while (!out_valid && n < 20) begin
         tick(1);
         n++;
      end
      check_val("stats_first_valid", out_valid, 1);
      out_ready = 1'b0;
      tick(3);
      out_ready = 1'b1;
      wait_drain();
      check_val("stats_done", done_cnt, 7);
      check_val("stats_stall", stall_cnt, 3);
`endif

      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/barret_rr_sched_3221.md
Name: barret_rr_sched_3221

Overview:
- Shares one combinational barret_for_3221 reducer (23-bit in, 12-bit out, mod 3221) among NUM_REQ requesters.
- Round-robin arbitration feeds a 2-stage valid/ready pipeline around the reducer.
- Each result carries the requester index so downstream logic can route it.
- Sits between the polynomial-coefficient producers and the shared modular-reduction resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 23, input operand width (fixed by reducer).
- RES_W, 12, result width (fixed by reducer).
- TAG_W, 2, requester index width; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*DATA_W  packed operands; requester i occupies bits [i*23 +: 23].
- req_ready  out  NUM_REQ  one-hot grant; transfer for requester i occurs when req_valid[i] && req_ready[i].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  RES_W  operand mod 3221.
- out_tag  out  TAG_W  index of the requester that issued the operand.
- busy  out  1  high while either pipeline stage holds data.

Behaviour:
- Reset (async assert, sync release): both stage-valid flags = 0, rr pointer = 0, out_valid = 0, out_data = 0, out_tag = 0, busy = 0. The req_ready vector is combinational and reads 0 while rst_n is low.
- Stage S0 register: operand plus tag, captured from the granted requester.
- Stage S1 register: reducer output driven from S0 operand, plus S0 tag. out_data and out_tag come directly from S1.
- Advance conditions:
  - s1_adv = !s1_v || out_ready.
  - s0_adv = !s0_v || s1_adv.
  - S1 loads when s1_adv: s1_v <= s0_v.
  - S0 loads when s0_adv: s0_v <= grant_any.
- Latency: accept on edge N; out_valid high after edge N+1 with no backpressure (result visible one cycle after S0 capture, i.e. 2 edges from request presentation). Throughput 1 result/cycle.
- Arbitration (combinational, only when s0_adv):
  - Search starts at the rr pointer and goes upward, wrapping NUM_REQ-1 -> 0; first asserted req_valid wins.
  - At most one req_ready bit is high. req_ready = 0 for all requesters when !s0_adv.
  - After a grant to requester g, the pointer becomes (g+1) mod NUM_REQ. The pointer is unchanged when there is no grant.
- Backpressure:
  - out_valid && !out_ready: out_data and out_tag are held stable, and S1 is not overwritten.
  - S0 also stalls if occupied; a maximum of 2 operands are in flight.
- Simultaneous consume and accept in one cycle: S1 takes S0 and S0 takes the new grant; no bubble, no loss.
- Requester dropping req_valid without a grant: no effect. A requester that is not granted must hold req_data stable while valid is high.
- Reset mid-operation flushes both stages; in-flight results are discarded and not replayed.
- busy = s0_v || s1_v.
- Reducer correctness is required only for operands 0..2^23-1.

Optional Feature:
- Macro BARRET_STATS_EN.
- Defined:
  - Adds output port done_cnt (16 bits). It increments on each out_valid && out_ready, saturates at 16'hFFFF, and resets to 0 on rst_n.
  - Adds output port stall_cnt (16 bits). It increments each cycle out_valid && !out_ready, with the same saturation and reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single request, out_ready=1: req 0 sends 3221 -> out_valid 2 cycles later with out_data=0, out_tag=0; then 8388607 -> out_data=1123.
- Contention: all 4 requesters valid in the same cycle with data 3222, 3223, 3224, 3225, pointer=0 -> results 1, 2, 3, 4 on consecutive cycles with tags 0, 1, 2, 3; pointer ends at 0.
- Fairness: requesters 1 and 3 held valid continuously -> grants alternate 1, 3, 1, 3; neither is granted twice in a row.
- Backpressure: stream 10 operands from req 2 while out_ready is held low 5 cycles -> exactly 2 accepted, req_ready=0 during the stall, out_data stable. After release, all 10 results arrive in order with no loss or duplicate.
- Reset mid-operation: assert rst_n low with both stages full -> out_valid=0, busy=0 immediately (async); after release the first new operand 6442 gives out_data=0, tag correct.
- BARRET_STATS_EN: 7 completed transfers plus 3 stall cycles -> done_cnt=7, stall_cnt=3. With the macro undefined, the bench compiles without those ports.
